usb_spectrum_link: RTL and testbench
====================================

Name: usb_spectrum_link

Overview:
- Parametrised successor to the fixed 16-bit, 1024-channel USB command/readout block, with all logic in the single CLOCK_50 domain.
- Decodes host command words from the USB read FIFO into one-cycle control pulses.
- On FETCH, walks the channel count memory and streams each count to the USB write FIFO as DATA_W-wide words, least-significant word first.
- Adds over the previous generation: configurable widths and channel count, configurable memory read latency, a busy flag, and an optional framed stream.

Parameters:
- DATA_W, 16, USB word width; COUNT_W must be an integer multiple of DATA_W.
- COUNT_W, 32, channel count width.
- ADDR_W, 10, channel address width.
- NUM_CH, 1024, channels streamed per fetch; 1 <= NUM_CH <= 2**ADDR_W.
- RD_LAT, 1, cycles from channel_address change to valid channel_count; range 1..4.
- CMD_FETCH / CMD_START / CMD_PAUSE / CMD_CLEAR, 16'hFFFF / 16'hFFEE / 16'hFFDD / 16'hFFCC, command codes, zero-extended/truncated to DATA_W.

Ports:
- CLOCK_50  in  1  sole clock, all logic on rising edge
- rst  in  1  reset, synchronous, active-high
- usb_read_data  in  DATA_W  read FIFO data
- usb_read_wait  in  1  high = read FIFO empty
- usb_read_en  out  1  read strobe
- usb_write_data  out  DATA_W  write FIFO data
- usb_write_en  out  1  write strobe
- usb_write_wait  in  1  high = write FIFO full
- channel_count  in  COUNT_W  count memory read data
- channel_address  out  ADDR_W  count memory address
- cmd_start  out  1  one-cycle pulse
- cmd_pause  out  1  one-cycle pulse
- cmd_clear  out  1  one-cycle pulse
- busy  out  1  high while a fetch stream is in progress
- last_cmd  out  DATA_W  last word read from USB

Behaviour:
Reset:
- Applies only at a CLOCK_50 edge with rst=1.
- Clears all outputs to 0; read FSM goes to R_IDLE, write FSM to W_IDLE.
- A reset during a stream abandons it immediately; no further usb_write_en.

Read FSM (R_IDLE, R_STROBE, R_CAPTURE, R_HOLD):
- R_IDLE: if usb_read_wait=0, go to R_STROBE.
- R_STROBE: usb_read_en=1 for exactly one cycle.
- R_CAPTURE: latch usb_read_data into last_cmd and decode it.
  - Decoding START, PAUSE or CLEAR drives the matching cmd_* high for exactly the following cycle.
  - FETCH raises an internal fetch request.
  - Any other word updates last_cmd only.
- R_HOLD: one idle cycle, then back to R_IDLE.
- Minimum read period is 4 cycles, so command pulses never overlap.
- FETCH while busy=1 is ignored (no restart). START/PAUSE/CLEAR while busy still pulse, and the stream continues.

Write FSM (W_IDLE, W_HDR, W_ADDR, W_WAIT, W_SEND, W_CSUM):
- WORDS = COUNT_W/DATA_W.
- W_IDLE: on fetch request, set channel_address=0, word index=0, busy=1, and go to W_HDR (framed build) or W_ADDR.
- W_ADDR: hold channel_address and load the latency counter with RD_LAT; go to W_WAIT.
- W_WAIT: decrement the counter; at 0, latch channel_count into a COUNT_W shift register and go to W_SEND.
- W_SEND:
  - When usb_write_wait=0: drive usb_write_data = shift[DATA_W-1:0] and usb_write_en=1 for one cycle, then shift right by DATA_W and increment the word index.
  - When usb_write_wait=1: hold with usb_write_en=0 and do not advance.
  - After WORDS writes: if channel_address = NUM_CH-1, go to W_CSUM (framed) or W_IDLE with busy=0; otherwise increment channel_address and go to W_ADDR.
- usb_write_en is never high on two consecutive cycles: a one-cycle gap follows each write.
- channel_address never exceeds NUM_CH-1 (no wrap).
- Total data words per fetch = NUM_CH*WORDS.

Optional Feature:
- Macro: USB_FRAME_EN.
- Defined:
  - W_HDR sends a header word 16'hA55A (truncated to DATA_W), followed by a word equal to NUM_CH[DATA_W-1:0], using the same wait/gap rules.
  - W_CSUM sends one trailer word: the sum mod 2**DATA_W of all data words in the frame, excluding the header words.
  - busy clears after the trailer is written.
- Not defined: W_HDR and W_CSUM are absent and the stream is data words only.

Test Plan:
- rst=1 for 2 cycles, then usb_read_wait=1 -> all outputs 0; no usb_read_en.
- Feed 16'hFFEE, then 16'hFFCC -> exactly one cmd_start pulse, then one cmd_clear pulse, each 1 cycle wide; last_cmd=16'hFFCC.
- NUM_CH=4, RD_LAT=2, counts 32'h0001_0002, 32'h0, 32'hFFFF_FFFF, 32'h1234_5678, write_wait=0, FETCH -> writes 0002,0001,0000,0000,FFFF,FFFF,5678,1234; busy high throughout, low after the last write.
- Same stream with usb_write_wait=1 for 10 cycles mid-stream -> no write while wait=1; no words lost or duplicated.
- Second FETCH while busy -> ignored, stream count stays 8. rst mid-stream -> no further writes; channel_address=0.
- USB_FRAME_EN, NUM_CH=2, counts 1 and 2 -> A55A, 0002, 0001, 0000, 0002, 0000, 0003.

Source files
------------

// File: rtl/usb_spectrum_link.sv
// USB command decoder and channel-count streamer, single CLOCK_50 domain.
// Define USB_FRAME_EN to wrap each fetch stream in a header and checksum trailer.
module usb_spectrum_link #(
  parameter int          DATA_W    = 16,
  parameter int          COUNT_W   = 32,
  parameter int          ADDR_W    = 10,
  parameter int          NUM_CH    = 1024,
  parameter int          RD_LAT    = 1,
  parameter logic [15:0] CMD_FETCH = 16'hFFFF,
  parameter logic [15:0] CMD_START = 16'hFFEE,
  parameter logic [15:0] CMD_PAUSE = 16'hFFDD,
  parameter logic [15:0] CMD_CLEAR = 16'hFFCC
) (
  input  logic               CLOCK_50,
  input  logic               rst,
  input  logic [DATA_W-1:0]  usb_read_data,
  input  logic               usb_read_wait,
  output logic               usb_read_en,
  output logic [DATA_W-1:0]  usb_write_data,
  output logic               usb_write_en,
  input  logic               usb_write_wait,
  input  logic [COUNT_W-1:0] channel_count,
  output logic [ADDR_W-1:0]  channel_address,
  output logic               cmd_start,
  output logic               cmd_pause,
  output logic               cmd_clear,
  output logic               busy,
  output logic [DATA_W-1:0]  last_cmd
);

  localparam int WORDS = COUNT_W / DATA_W;
  localparam int IDX_W = $clog2(WORDS + 1);
  localparam int LAT_W = 3;

  localparam logic [DATA_W-1:0] FETCH_CODE = DATA_W'(CMD_FETCH);
  localparam logic [DATA_W-1:0] START_CODE = DATA_W'(CMD_START);
  localparam logic [DATA_W-1:0] PAUSE_CODE = DATA_W'(CMD_PAUSE);
  localparam logic [DATA_W-1:0] CLEAR_CODE = DATA_W'(CMD_CLEAR);
  localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(NUM_CH - 1);
  localparam logic [IDX_W-1:0]  LAST_IDX   = IDX_W'(WORDS - 1);
  localparam logic [LAT_W-1:0]  LAT_LOAD   = LAT_W'(RD_LAT);

  // ---------------------------------------------------------------- read side
  typedef enum logic [1:0] {R_IDLE, R_STROBE, R_CAPTURE, R_HOLD} rd_state_t;

  rd_state_t         rd_state_q, rd_state_d;
  logic [DATA_W-1:0] last_cmd_q, last_cmd_d;
  logic              cmd_start_q, cmd_start_d;
  logic              cmd_pause_q, cmd_pause_d;
  logic              cmd_clear_q, cmd_clear_d;
  logic              fetch_req;

  always_ff @(posedge CLOCK_50) begin
    if (rst) begin
      rd_state_q  <= R_IDLE;
      last_cmd_q  <= '0;
      cmd_start_q <= 1'b0;
      cmd_pause_q <= 1'b0;
      cmd_clear_q <= 1'b0;
    end else begin
      rd_state_q  <= rd_state_d;
      last_cmd_q  <= last_cmd_d;
      cmd_start_q <= cmd_start_d;
      cmd_pause_q <= cmd_pause_d;
      cmd_clear_q <= cmd_clear_d;
    end
  end

  always_comb begin
    rd_state_d  = rd_state_q;
    last_cmd_d  = last_cmd_q;
    cmd_start_d = 1'b0;
    cmd_pause_d = 1'b0;
    cmd_clear_d = 1'b0;
    fetch_req   = 1'b0;
    case (rd_state_q)
      R_IDLE:   if (!usb_read_wait) rd_state_d = R_STROBE;
      R_STROBE: rd_state_d = R_CAPTURE;
      R_CAPTURE: begin
        // FIFO data is valid the cycle after the strobe; pulses land in R_HOLD.
        last_cmd_d  = usb_read_data;
        cmd_start_d = (usb_read_data == START_CODE);
        cmd_pause_d = (usb_read_data == PAUSE_CODE);
        cmd_clear_d = (usb_read_data == CLEAR_CODE);
        fetch_req   = (usb_read_data == FETCH_CODE);
        rd_state_d  = R_HOLD;
      end
      R_HOLD:   rd_state_d = R_IDLE;
      default:  rd_state_d = R_IDLE;
    endcase
  end

  assign usb_read_en = (rd_state_q == R_STROBE);
  assign last_cmd    = last_cmd_q;
  assign cmd_start   = cmd_start_q;
  assign cmd_pause   = cmd_pause_q;
  assign cmd_clear   = cmd_clear_q;

  // --------------------------------------------------------------- write side
  // Write handshake: a word transfers in any cycle where usb_write_en=1, and
  // usb_write_en is only raised while usb_write_wait=0, never on back-to-back cycles.
  typedef enum logic [2:0] {
    W_IDLE,
    W_ADDR,
    W_WAIT,
    W_SEND
`ifdef USB_FRAME_EN
    ,
    W_HDR,
    W_CSUM
`endif
  } wr_state_t;

  wr_state_t          wr_state_q, wr_state_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [LAT_W-1:0]   lat_q, lat_d;
  logic [COUNT_W-1:0] shift_q, shift_d;
  logic               gap_q, gap_d;
  logic               busy_q, busy_d;
  logic               write_ok;
`ifdef USB_FRAME_EN
  localparam logic [DATA_W-1:0] HDR_WORD = DATA_W'(16'hA55A);
  localparam logic [DATA_W-1:0] NCH_WORD = DATA_W'(NUM_CH);
  logic [DATA_W-1:0]  csum_q, csum_d;
`endif

  always_ff @(posedge CLOCK_50) begin
    if (rst) begin
      wr_state_q <= W_IDLE;
      addr_q     <= '0;
      idx_q      <= '0;
      lat_q      <= '0;
      shift_q    <= '0;
      gap_q      <= 1'b0;
      busy_q     <= 1'b0;
`ifdef USB_FRAME_EN
      csum_q     <= '0;
`endif
    end else begin
      wr_state_q <= wr_state_d;
      addr_q     <= addr_d;
      idx_q      <= idx_d;
      lat_q      <= lat_d;
      shift_q    <= shift_d;
      gap_q      <= gap_d;
      busy_q     <= busy_d;
`ifdef USB_FRAME_EN
      csum_q     <= csum_d;
`endif
    end
  end

  assign write_ok = !gap_q && !usb_write_wait;

  always_comb begin
    wr_state_d     = wr_state_q;
    addr_d         = addr_q;
    idx_d          = idx_q;
    lat_d          = lat_q;
    shift_d        = shift_q;
    gap_d          = 1'b0;
    busy_d         = busy_q;
    usb_write_en   = 1'b0;
    usb_write_data = '0;
`ifdef USB_FRAME_EN
    csum_d         = csum_q;
`endif
    case (wr_state_q)
      W_IDLE: begin
        busy_d = 1'b0;
        if (fetch_req) begin
          addr_d = '0;
          idx_d  = '0;
          busy_d = 1'b1;
`ifdef USB_FRAME_EN
          csum_d     = '0;
          wr_state_d = W_HDR;
`else
          wr_state_d = W_ADDR;
`endif
        end
      end
`ifdef USB_FRAME_EN
      W_HDR: begin
        if (write_ok) begin
          usb_write_en   = 1'b1;
          usb_write_data = (idx_q == '0) ? HDR_WORD : NCH_WORD;
          gap_d          = 1'b1;
          if (idx_q == IDX_W'(1)) begin
            idx_d      = '0;
            wr_state_d = W_ADDR;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
`endif
      W_ADDR: begin
        lat_d      = LAT_LOAD;
        wr_state_d = W_WAIT;
      end
      W_WAIT: begin
        // Count reaches zero on this edge: memory output has settled.
        lat_d = lat_q - LAT_W'(1);
        if (lat_q <= LAT_W'(1)) begin
          shift_d    = channel_count;
          idx_d      = '0;
          wr_state_d = W_SEND;
        end
      end
      W_SEND: begin
        if (write_ok) begin
          usb_write_en   = 1'b1;
          usb_write_data = shift_q[DATA_W-1:0];
          shift_d        = shift_q >> DATA_W;
          gap_d          = 1'b1;
`ifdef USB_FRAME_EN
          csum_d         = csum_q + shift_q[DATA_W-1:0];
`endif
          if (idx_q == LAST_IDX) begin
            idx_d = '0;
            if (addr_q == LAST_ADDR) begin
`ifdef USB_FRAME_EN
              wr_state_d = W_CSUM;
`else
              wr_state_d = W_IDLE;
              busy_d     = 1'b0;
`endif
            end else begin
              addr_d     = addr_q + ADDR_W'(1);
              wr_state_d = W_ADDR;
            end
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
`ifdef USB_FRAME_EN
      W_CSUM: begin
        if (write_ok) begin
          usb_write_en   = 1'b1;
          usb_write_data = csum_q;
          gap_d          = 1'b1;
          busy_d         = 1'b0;
          wr_state_d     = W_IDLE;
        end
      end
`endif
      default: wr_state_d = W_IDLE;
    endcase
  end

  assign channel_address = addr_q;
  assign busy            = busy_q;

endmodule

// File: tb/tb_usb_spectrum_link.sv
// Directed bench for usb_spectrum_link: commands, plain and stalled fetches,
// fetch-while-busy, command-while-busy and reset mid-stream.
module tb_usb_spectrum_link;
  localparam int DATA_W  = 16;
  localparam int COUNT_W = 32;
  localparam int ADDR_W  = 10;
  localparam int NUM_CH  = 4;
  localparam int RD_LAT  = 2;

  logic               CLOCK_50 = 1'b0;
  logic               rst = 1'b1;
  logic [DATA_W-1:0]  usb_read_data = '0;
  logic               usb_read_wait = 1'b1;
  logic               usb_read_en;
  logic [DATA_W-1:0]  usb_write_data;
  logic               usb_write_en;
  logic               usb_write_wait = 1'b0;
  logic [COUNT_W-1:0] channel_count;
  logic [ADDR_W-1:0]  channel_address;
  logic               cmd_start, cmd_pause, cmd_clear, busy;
  logic [DATA_W-1:0]  last_cmd;

  // clock / reset
  always #5 CLOCK_50 = ~CLOCK_50;

  usb_spectrum_link #(
    .DATA_W(DATA_W), .COUNT_W(COUNT_W), .ADDR_W(ADDR_W),
    .NUM_CH(NUM_CH), .RD_LAT(RD_LAT)
  ) dut (
    .CLOCK_50(CLOCK_50), .rst(rst),
    .usb_read_data(usb_read_data), .usb_read_wait(usb_read_wait),
    .usb_read_en(usb_read_en),
    .usb_write_data(usb_write_data), .usb_write_en(usb_write_en),
    .usb_write_wait(usb_write_wait),
    .channel_count(channel_count), .channel_address(channel_address),
    .cmd_start(cmd_start), .cmd_pause(cmd_pause), .cmd_clear(cmd_clear),
    .busy(busy), .last_cmd(last_cmd)
  );

  // count memory with a two-register read pipeline (RD_LAT = 2)
  logic [COUNT_W-1:0] mem [NUM_CH];
  logic [COUNT_W-1:0] pipe0, pipe1;
  always @(posedge CLOCK_50) begin
    pipe0 <= mem[channel_address[1:0]];
    pipe1 <= pipe0;
  end
  assign channel_count = pipe1;

  // monitor: records writes and protocol counters, sampled after the falling edge
  logic [DATA_W-1:0] got_q[$];
  logic [DATA_W-1:0] exp_q[$];
  int rd_cycles = 0, start_hi = 0, pause_hi = 0, clear_hi = 0, wide_pulses = 0;
  int en_on_wait = 0, en_back2back = 0, en_not_busy = 0, max_addr = 0;
  logic prev_en = 1'b0, prev_s = 1'b0, prev_p = 1'b0, prev_c = 1'b0;

  always begin
    @(negedge CLOCK_50);
    #1;
    if (usb_read_en === 1'b1) rd_cycles++;
    if (cmd_start === 1'b1) begin start_hi++; if (prev_s) wide_pulses++; end
    if (cmd_pause === 1'b1) begin pause_hi++; if (prev_p) wide_pulses++; end
    if (cmd_clear === 1'b1) begin clear_hi++; if (prev_c) wide_pulses++; end
    if (usb_write_en === 1'b1) begin
      got_q.push_back(usb_write_data);
      if (usb_write_wait) en_on_wait++;
      if (prev_en) en_back2back++;
      if (busy !== 1'b1) en_not_busy++;
    end
    if (int'(channel_address) > max_addr) max_addr = int'(channel_address);
    prev_en = (usb_write_en === 1'b1);
    prev_s  = (cmd_start === 1'b1);
    prev_p  = (cmd_pause === 1'b1);
    prev_c  = (cmd_clear === 1'b1);
  end

  // scoreboard
  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // driver tasks
  task automatic send_cmd(input logic [DATA_W-1:0] w);
    int t;
    t = 0;
    usb_read_data = w;
    usb_read_wait = 1'b0;
    @(negedge CLOCK_50);
    while (usb_read_en !== 1'b1 && t < 20) begin
      @(negedge CLOCK_50);
      t++;
    end
    check("read_strobe_timeout", (t < 20), 1);
    usb_read_wait = 1'b1;
    repeat (4) @(negedge CLOCK_50);
  endtask

  task automatic wait_busy_low();
    int t;
    t = 0;
    while (busy !== 1'b0 && t < 500) begin
      @(negedge CLOCK_50);
      t++;
    end
    check("busy_low_timeout", (t < 500), 1);
  endtask

  task automatic wait_words(input int n);
    int t;
    t = 0;
    while (got_q.size() < n && t < 500) begin
      @(negedge CLOCK_50);
      t++;
    end
    check("words_timeout", (t < 500), 1);
  endtask

  task automatic compare_stream(input string tag, input int base);
    int n;
    n = got_q.size() - base;
    check({tag, "_count"}, n, exp_q.size());
    for (int i = 0; i < exp_q.size(); i++)
      if (i < n) check($sformatf("%s_word%0d", tag, i), got_q[base + i], exp_q[i]);
  endtask

  // hand-computed data words for counts 0001_0002, 0, FFFF_FFFF, 1234_5678
  logic [DATA_W-1:0] data_vec [8] = '{16'h0002, 16'h0001, 16'h0000, 16'h0000,
                                      16'hFFFF, 16'hFFFF, 16'h5678, 16'h1234};

  task automatic build_exp();
    logic [DATA_W-1:0] sum;
    sum = '0;
    exp_q.delete();
`ifdef USB_FRAME_EN
    exp_q.push_back(16'hA55A);
    exp_q.push_back(16'(NUM_CH));
`endif
    for (int i = 0; i < 8; i++) begin
      exp_q.push_back(data_vec[i]);
      sum = sum + data_vec[i];
    end
`ifdef USB_FRAME_EN
    exp_q.push_back(sum);
`endif
  endtask

  int base;
  int n_after;
  int p0;

  initial begin
    mem[0] = 32'h0001_0002;
    mem[1] = 32'h0000_0000;
    mem[2] = 32'hFFFF_FFFF;
    mem[3] = 32'h1234_5678;
    build_exp();

    // reset for two cycles, read FIFO empty
    repeat (2) @(negedge CLOCK_50);
    rst = 1'b0;
    check("rst_read_en", usb_read_en, 0);
    check("rst_write_en", usb_write_en, 0);
    check("rst_write_data", usb_write_data, 0);
    check("rst_address", channel_address, 0);
    check("rst_cmd_start", cmd_start, 0);
    check("rst_cmd_pause", cmd_pause, 0);
    check("rst_cmd_clear", cmd_clear, 0);
    check("rst_busy", busy, 0);
    check("rst_last_cmd", last_cmd, 0);
    repeat (5) @(negedge CLOCK_50);
    check("idle_no_read", rd_cycles, 0);

    // START then CLEAR, then a non-command word
    send_cmd(16'hFFEE);
    send_cmd(16'hFFCC);
    check("start_pulses", start_hi, 1);
    check("clear_pulses", clear_hi, 1);
    check("pause_pulses", pause_hi, 0);
    check("pulse_width", wide_pulses, 0);
    check("last_cmd_clear", last_cmd, 16'hFFCC);
    check("read_strobes", rd_cycles, 2);
    send_cmd(16'h1234);
    check("last_cmd_other", last_cmd, 16'h1234);
    check("other_no_start", start_hi, 1);
    check("other_no_clear", clear_hi, 1);

    // plain fetch
    base = got_q.size();
    send_cmd(16'hFFFF);
    check("busy_during_fetch", busy, 1);
    wait_busy_low();
    repeat (10) @(negedge CLOCK_50);
    compare_stream("plain", base);

    // fetch with a 10-cycle write stall after the third word
    base = got_q.size();
    send_cmd(16'hFFFF);
    wait_words(base + 3);
    usb_write_wait = 1'b1;
    repeat (10) @(negedge CLOCK_50);
    check("stall_no_words", got_q.size() - base, 3);
    check("stall_busy", busy, 1);
    usb_write_wait = 1'b0;
    wait_busy_low();
    repeat (10) @(negedge CLOCK_50);
    compare_stream("stall", base);

    // second FETCH while busy is ignored
    base = got_q.size();
    send_cmd(16'hFFFF);
    wait_words(base + 2);
    send_cmd(16'hFFFF);
    check("refetch_busy", busy, 1);
    wait_busy_low();
    repeat (20) @(negedge CLOCK_50);
    compare_stream("refetch", base);

    // PAUSE while busy, then reset mid-stream
    base = got_q.size();
    p0 = pause_hi;
    send_cmd(16'hFFFF);
    wait_words(base + 1);
    send_cmd(16'hFFDD);
    check("pause_while_busy", pause_hi, p0 + 1);
    wait_words(base + 3);
    check("busy_before_rst", busy, 1);
    rst = 1'b1;
    @(negedge CLOCK_50);
    rst = 1'b0;
    n_after = got_q.size();
    check("midrst_address", channel_address, 0);
    check("midrst_busy", busy, 0);
    check("midrst_write_en", usb_write_en, 0);
    repeat (30) @(negedge CLOCK_50);
    check("midrst_no_writes", got_q.size(), n_after);

    // protocol invariants over the whole run
    check("en_while_wait", en_on_wait, 0);
    check("en_back_to_back", en_back2back, 0);
    check("en_without_busy", en_not_busy, 0);
    check("address_bound", (max_addr <= NUM_CH - 1), 1);
    check("pulse_width_final", wide_pulses, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
